mpsk_phase_sequencer: RTL
=========================

Name: mpsk_phase_sequencer

Overview:
Parametrised M-PSK successor to the fixed BPSK phase lookup. Accepts symbols of BITS_PER_SYMBOL bits over a valid/ready handshake and holds each symbol for CYCLES_PER_SYMBOL carrier cycles. For every sample it emits a sine-table address: the carrier sample index, rotated by the symbol's phase offset, modulo WAVELENGTH. It sits between the symbol source (framer/FIFO) and the sine ROM.

Parameters:
BITS_PER_SYMBOL, 2, bits per symbol; M = 2**BITS_PER_SYMBOL (1 = BPSK, 2 = QPSK, 3 = 8PSK).
WAVELENGTH, 16, samples per carrier cycle (sine table depth); must be divisible by M.
CYCLES_PER_SYMBOL, 1, carrier cycles per symbol; must be at least 1.
GRAY_CODE, 1, 1 = Gray-coded constellation, 0 = natural binary.

Ports:
clk  in  1  system clock
rst_n  in  1  asynchronous active-low reset
enable  in  1  sample strobe; counters advance only when high
sym_data  in  BITS_PER_SYMBOL  symbol value
sym_valid  in  1  sym_data is valid
sym_ready  out  1  block accepts a symbol this cycle
phase  out  $clog2(WAVELENGTH)  sine table address
phase_valid  out  1  phase holds a new sample
sym_start  out  1  phase is sample 0 of a symbol
underrun  out  1  one-cycle pulse: symbol ended and no successor was available

Behaviour:
- Reset (async, rst_n low): state=IDLE; sample counter, cycle counter and symbol register cleared. Outputs: phase=0, phase_valid=0, sym_start=0, underrun=0.
- Derived constants: STEP = WAVELENGTH/M. Position k = (M-1) - G(s), where G = gray_to_bin when GRAY_CODE=1 and identity otherwise. Offset = k*STEP.
- The mapping keeps BPSK legacy behaviour: symbol 1 gets offset 0 and symbol 0 gets offset WAVELENGTH/2.
- States: IDLE (no active symbol) and RUN.
- last_sample = RUN and samp==WAVELENGTH-1 and cyc==CYCLES_PER_SYMBOL-1.
- sym_ready = enable and (IDLE or last_sample). It is combinational and does not depend on sym_valid.
- Accept = sym_valid and sym_ready. On accept, the symbol is latched, samp=0, cyc=0, and state goes to RUN.
- In RUN with enable high:
  - Registered outputs: phase <= (samp + offset) mod WAVELENGTH; phase_valid <= 1; sym_start <= (samp==0 and cyc==0).
  - samp increments and wraps at WAVELENGTH-1; cyc increments on each samp wrap.
- At last_sample with no accept: state goes to IDLE, and underrun <= 1 in the same registered cycle as the final sample.
- At last_sample with an accept: the next symbol starts seamlessly and sample 0 is emitted on the next enabled cycle with no gap.
- Latency: a symbol accepted in cycle t produces its sample 0 at the outputs in cycle t+2.
- enable low:
  - Counters, state and symbol are frozen.
  - phase_valid=0, sym_start=0, underrun=0; phase holds its last value.
- IDLE: phase_valid=0, phase holds its last value.
- sym_data is ignored when no accept occurs.
- The modulo is implemented as a compare-subtract on a $clog2(WAVELENGTH)+1-bit sum. A power-of-2 table is not assumed.
- Reset mid-symbol: outputs clear immediately; the symbol in flight is dropped.

Decomposition:
- Package psk_pkg:
  - function gray_to_bin;
  - localparam helpers for M and STEP;
  - state enum {IDLE, RUN}.
- Sub-module psk_symbol_mapper: combinational, maps symbol to offset using GRAY_CODE and STEP.
- The top level owns the counters, FSM, handshake and output registers.

Test Plan:
1. Reset check (defaults): hold rst_n low, then release -> phase=0, phase_valid=0, sym_ready=1 while enable=1, underrun=0.
2. Single symbol, QPSK Gray, enable=1: s=2 (offset 0) accepted at t -> phase 0..15 valid t+2..t+17, sym_start only at t+2, underrun=1 at t+17, phase_valid=0 at t+18. Repeat with s=0 (offset 12) -> phase 12,13,14,15,0..11.
3. Back-to-back: s=0 then s=1 with sym_valid held -> sym_ready high only at last_sample; second symbol emits 8..15,0..7 immediately after 11 with no gap; no underrun between the symbols.
4. BPSK legacy (BITS_PER_SYMBOL=1, WAVELENGTH=10): symbol 1 -> 0..9; symbol 0 -> 5..9,0..4.
5. Enable gating: deassert enable for 3 cycles after sample 5 -> phase_valid=0 for those cycles, phase holds at 5; on re-enable, the next sample is 6; total valid samples = 16.
6. CYCLES_PER_SYMBOL=2: s=3 (offset 4) -> 32 samples, wrapping 4..15,0..3 twice; sym_start once. Separately, assert rst_n at sample 7 -> outputs clear asynchronously; state is IDLE after release.

Source files
------------

// File: rtl/psk_pkg.sv
// rtl/psk_pkg.sv - shared types and constellation helpers for the M-PSK phase sequencer
package psk_pkg;

    typedef enum logic {
        ST_IDLE = 1'b0,
        ST_RUN  = 1'b1
    } psk_state_t;

    function automatic int psk_m(input int bits);
        return 1 << bits;
    endfunction

    function automatic int psk_step(input int wavelength, input int bits);
        return wavelength / (1 << bits);
    endfunction

    // Inverse Gray code: each binary bit is the XOR of all Gray bits at or above it.
    function automatic logic [7:0] gray_to_bin(input logic [7:0] g);
        logic [7:0] b;
        b = g;
        for (int i = 1; i < 8; i++) begin
            b = b ^ (g >> i);
        end
        return b;
    endfunction

endpackage

// File: rtl/psk_symbol_mapper.sv
// rtl/psk_symbol_mapper.sv - maps a symbol to its sine-table phase offset
module psk_symbol_mapper
    import psk_pkg::*;
#(
    parameter int BITS_PER_SYMBOL = 2,
    parameter int WAVELENGTH      = 16,
    parameter int GRAY_CODE       = 1,
    localparam int PW             = $clog2(WAVELENGTH)
) (
    input  logic [BITS_PER_SYMBOL-1:0] i_sym,
    output logic [PW-1:0]              o_offset
);

    localparam int M    = psk_m(BITS_PER_SYMBOL);
    localparam int STEP = psk_step(WAVELENGTH, BITS_PER_SYMBOL);

    logic [7:0] w_sym;
    logic [7:0] w_pos;

    assign w_sym = 8'(i_sym);
    assign w_pos = (GRAY_CODE != 0) ? gray_to_bin(w_sym) : w_sym;

    // Positions are counted down from M-1 so BPSK symbol 1 keeps offset 0.
    assign o_offset = PW'((M - 1 - int'(w_pos)) * STEP);

endmodule

// File: rtl/mpsk_phase_sequencer.sv
// rtl/mpsk_phase_sequencer.sv - M-PSK symbol handshake, carrier counters and sine address output
module mpsk_phase_sequencer
    import psk_pkg::*;
#(
    parameter int BITS_PER_SYMBOL   = 2,
    parameter int WAVELENGTH        = 16,
    parameter int CYCLES_PER_SYMBOL = 1,
    parameter int GRAY_CODE         = 1,
    localparam int PW               = $clog2(WAVELENGTH)
) (
    input  logic                       clk,
    input  logic                       rst_n,
    input  logic                       enable,
    input  logic [BITS_PER_SYMBOL-1:0] sym_data,
    input  logic                       sym_valid,
    output logic                       sym_ready,
    output logic [PW-1:0]              phase,
    output logic                       phase_valid,
    output logic                       sym_start,
    output logic                       underrun
);

    localparam int CW = (CYCLES_PER_SYMBOL > 1) ? $clog2(CYCLES_PER_SYMBOL) : 1;

    psk_state_t                 r_state;
    logic [PW-1:0]              r_samp;
    logic [CW-1:0]              r_cyc;
    logic [BITS_PER_SYMBOL-1:0] r_sym;
    logic [PW-1:0]              r_phase;
    logic                       r_phase_valid;
    logic                       r_sym_start;
    logic                       r_underrun;

    logic [PW-1:0] w_offset;
    logic [PW:0]   w_sum;
    logic          w_wrap;
    logic [PW-1:0] w_phase_next;
    logic          w_samp_end;
    logic          w_last_sample;
    logic          w_accept;

    psk_symbol_mapper #(
        .BITS_PER_SYMBOL (BITS_PER_SYMBOL),
        .WAVELENGTH      (WAVELENGTH),
        .GRAY_CODE       (GRAY_CODE)
    ) u_mapper (
        .i_sym    (r_sym),
        .o_offset (w_offset)
    );

    // Compare-subtract modulo so non-power-of-two table depths work.
    assign w_sum        = {1'b0, r_samp} + {1'b0, w_offset};
    assign w_wrap       = (w_sum >= (PW+1)'(WAVELENGTH));
    assign w_phase_next = w_wrap ? PW'(w_sum - (PW+1)'(WAVELENGTH)) : PW'(w_sum);

    assign w_samp_end    = (r_samp == PW'(WAVELENGTH - 1));
    assign w_last_sample = (r_state == ST_RUN) && w_samp_end &&
                           (r_cyc == CW'(CYCLES_PER_SYMBOL - 1));
    assign sym_ready     = enable && ((r_state == ST_IDLE) || w_last_sample);
    assign w_accept      = sym_valid && sym_ready;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state       <= ST_IDLE;
            r_samp        <= '0;
            r_cyc         <= '0;
            r_sym         <= '0;
            r_phase       <= '0;
            r_phase_valid <= 1'b0;
            r_sym_start   <= 1'b0;
            r_underrun    <= 1'b0;
        end else begin
            r_phase_valid <= 1'b0;
            r_sym_start   <= 1'b0;
            r_underrun    <= 1'b0;
            if (enable) begin
                if (r_state == ST_RUN) begin
                    r_phase       <= w_phase_next;
                    r_phase_valid <= 1'b1;
                    r_sym_start   <= (r_samp == '0) && (r_cyc == '0);
                    if (w_samp_end) begin
                        r_samp <= '0;
                        r_cyc  <= (r_cyc == CW'(CYCLES_PER_SYMBOL - 1)) ? '0 : r_cyc + 1'b1;
                    end else begin
                        r_samp <= r_samp + 1'b1;
                    end
                    if (w_last_sample && !w_accept) begin
                        r_state    <= ST_IDLE;
                        r_underrun <= 1'b1;
                    end
                end
                // A successor accepted on the last sample restarts the counters with no gap.
                if (w_accept) begin
                    r_sym   <= sym_data;
                    r_samp  <= '0;
                    r_cyc   <= '0;
                    r_state <= ST_RUN;
                end
            end
        end
    end

    assign phase       = r_phase;
    assign phase_valid = r_phase_valid;
    assign sym_start   = r_sym_start;
    assign underrun    = r_underrun;

endmodule
